// File: rtl/uart_port_if.sv
// Bus-side interface of the UART responder: the CPU data-bus valid/ready channel.
// Handshake: the initiator raises uart_valid with addr/wdata/wstrb stable and holds it until it
// sees uart_ready=1; the responder pulses uart_ready for exactly one cycle, with uart_rdata valid
// only in that cycle. uart_wstrb!=0 marks a write, uart_wstrb==0 a read.
interface uart_port_if;
  logic        uart_valid;
  logic        uart_instr;
  logic [31:0] uart_addr;
  logic [31:0] uart_wdata;
  logic [3:0]  uart_wstrb;
  logic [31:0] uart_rdata;
  logic        uart_ready;

  modport master (
    output uart_valid, uart_instr, uart_addr, uart_wdata, uart_wstrb,
    input  uart_rdata, uart_ready
  );

  modport slave (
    input  uart_valid, uart_instr, uart_addr, uart_wdata, uart_wstrb,
    output uart_rdata, uart_ready
  );
endinterface

// File: rtl/uart_port.sv
// Memory-mapped 8N1 UART: TXDATA/STATUS/RXDATA/DIV registers, TX FIFO and serialiser.
// The receiver (synchroniser, RX FSM, rx flags, interrupt) is built only when UART_RX_EN is defined.
module uart_port #(
  parameter int CLK_DIV  = 868,
  parameter int TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  uart_port_if.slave bus,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       uart_irpt,
  output logic [1:0] o_tx_state,
  output logic [1:0] o_rx_state
);

  localparam int          AW       = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(TX_DEPTH);
  localparam logic [15:0] DIV_RST  = 16'(CLK_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } ser_state_t;

  logic        r_ready;
  logic [31:0] r_rdata;
  logic [15:0] r_div;
  logic        r_tx_ovf;

  logic [7:0]    r_fifo [TX_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;

  ser_state_t  r_tx_state, w_tx_state_nxt;
  logic [15:0] r_tx_cnt, r_tx_div;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_sh;

  logic        w_accept, w_write, w_clr;
  logic        w_push_req, w_push, w_full, w_empty;
  logic        w_tx_pop, w_tx_cnt_end;
  logic [1:0]  w_reg;
  logic [15:0] w_div_new;
  logic [31:0] w_status, w_rd_val;
  logic        w_rx_valid, w_rx_ovr, w_rx_ferr;
  logic [7:0]  w_rx_byte;
  logic        w_unused;

  // A request is taken only while ready is low, so a held valid is accepted exactly once.
  assign w_accept   = bus.uart_valid && !r_ready;
  assign w_write    = |bus.uart_wstrb;
  assign w_reg      = bus.uart_addr[3:2];
  assign w_clr      = w_accept && w_write && (w_reg == 2'd1);
  assign w_push_req = w_accept && w_write && (w_reg == 2'd0) && bus.uart_wstrb[0];
  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_push     = w_push_req && !w_full;

  assign bus.uart_ready = r_ready;
  assign bus.uart_rdata = r_rdata;
  assign o_tx_state     = r_tx_state;
  assign w_unused       = ^{bus.uart_instr, bus.uart_addr[31:4], bus.uart_addr[1:0],
                            bus.uart_wdata[31:16]};

  always_comb begin
    w_div_new = r_div;
    if (bus.uart_wstrb[0]) w_div_new[7:0]  = bus.uart_wdata[7:0];
    if (bus.uart_wstrb[1]) w_div_new[15:8] = bus.uart_wdata[15:8];
    if (w_div_new < 16'd2) w_div_new = 16'd2;
  end

  assign w_status = {26'd0, w_rx_ferr, w_rx_ovr, r_tx_ovf, w_rx_valid,
                     w_empty && (r_tx_state == S_IDLE), w_full};

  always_comb begin
    w_rd_val = 32'd0;
    case (w_reg)
      2'd1:    w_rd_val = w_status;
      2'd2:    w_rd_val = {w_rx_valid, 23'd0, w_rx_byte};
      2'd3:    w_rd_val = {16'd0, r_div};
      default: w_rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ready  <= 1'b0;
      r_rdata  <= 32'd0;
      r_div    <= DIV_RST;
      r_tx_ovf <= 1'b0;
    end else begin
      r_ready <= w_accept;
      r_rdata <= (w_accept && !w_write) ? w_rd_val : 32'd0;
      if (w_accept && w_write && (w_reg == 2'd3)) r_div <= w_div_new;
      if (w_push_req && w_full)                r_tx_ovf <= 1'b1;
      else if (w_clr && bus.uart_wdata[3])     r_tx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= bus.uart_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)   r_wptr <= r_wptr + 1'b1;
      if (w_tx_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_tx_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_tx_cnt_end = (r_tx_cnt == r_tx_div - 16'd1);

  // STOP may chain straight into the next START so queued bytes leave without a gap.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_tx_pop       = 1'b1;
          w_tx_state_nxt = S_START;
        end
      end
      S_START: if (w_tx_cnt_end) w_tx_state_nxt = S_DATA;
      S_DATA:  if (w_tx_cnt_end && (r_tx_bit == 3'd7)) w_tx_state_nxt = S_STOP;
      S_STOP: begin
        if (w_tx_cnt_end) begin
          if (!w_empty) begin
            w_tx_pop       = 1'b1;
            w_tx_state_nxt = S_START;
          end else begin
            w_tx_state_nxt = S_IDLE;
          end
        end
      end
      default: w_tx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= 16'd0;
      r_tx_div   <= DIV_RST;
      r_tx_bit   <= 3'd0;
      r_tx_sh    <= 8'hFF;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      if (w_tx_pop) begin
        r_tx_sh  <= r_fifo[r_rptr];
        r_tx_div <= r_div;
        r_tx_cnt <= 16'd0;
        r_tx_bit <= 3'd0;
      end else if (r_tx_state != S_IDLE) begin
        if (w_tx_cnt_end) begin
          r_tx_cnt <= 16'd0;
          if (r_tx_state == S_DATA) begin
            r_tx_sh  <= {1'b1, r_tx_sh[7:1]};
            r_tx_bit <= r_tx_bit + 3'd1;
          end
        end else begin
          r_tx_cnt <= r_tx_cnt + 16'd1;
        end
      end
    end
  end

  always_comb begin
    uart_tx = 1'b1;
    case (r_tx_state)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = r_tx_sh[0];
      default: uart_tx = 1'b1;
    endcase
  end

`ifdef UART_RX_EN
  logic        r_rx_s1, r_rx_s2, r_rx_s3;
  ser_state_t  r_rx_state, w_rx_state_nxt;
  logic [15:0] r_rx_cnt, r_rx_div;
  logic [15:0] w_rx_target;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_sh, r_rx_byte;
  logic        r_rx_valid, r_rx_ovr, r_rx_ferr;
  logic        w_rx_end, w_rx_done, w_rx_bad_stop, w_rd_rxdata;

  assign w_rx_target   = (r_rx_state == S_START) ? ((r_rx_div >> 1) - 16'd1) : (r_rx_div - 16'd1);
  assign w_rx_end      = (r_rx_cnt == w_rx_target);
  assign w_rx_done     = (r_rx_state == S_STOP) && w_rx_end && r_rx_s2;
  assign w_rx_bad_stop = (r_rx_state == S_STOP) && w_rx_end && !r_rx_s2;
  assign w_rd_rxdata   = w_accept && !w_write && (w_reg == 2'd2);

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      S_IDLE:  if (r_rx_s3 && !r_rx_s2) w_rx_state_nxt = S_START;
      S_START: if (w_rx_end) w_rx_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (w_rx_end && (r_rx_bit == 3'd7)) w_rx_state_nxt = S_STOP;
      S_STOP:  if (w_rx_end) w_rx_state_nxt = S_IDLE;
      default: w_rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= 16'd0;
      r_rx_div   <= DIV_RST;
      r_rx_bit   <= 3'd0;
      r_rx_sh    <= 8'd0;
    end else begin
      r_rx_s1    <= uart_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_s3    <= r_rx_s2;
      r_rx_state <= w_rx_state_nxt;
      if (r_rx_state == S_IDLE) begin
        r_rx_cnt <= 16'd0;
        r_rx_bit <= 3'd0;
        r_rx_div <= r_div;
      end else if (w_rx_end) begin
        r_rx_cnt <= 16'd0;
        if (r_rx_state == S_DATA) begin
          r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 3'd1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt + 16'd1;
      end
    end
  end

  // Completion beats a same-cycle RXDATA read or clear-write; a read in that cycle forgives the overrun.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_byte  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      if (w_rx_done) begin
        r_rx_byte  <= r_rx_sh;
        r_rx_valid <= 1'b1;
      end else if (w_rd_rxdata) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_done && r_rx_valid && !w_rd_rxdata) r_rx_ovr <= 1'b1;
      else if (w_clr && bus.uart_wdata[4])         r_rx_ovr <= 1'b0;
      if (w_rx_bad_stop)                           r_rx_ferr <= 1'b1;
      else if (w_clr && bus.uart_wdata[5])         r_rx_ferr <= 1'b0;
    end
  end

  assign w_rx_valid = r_rx_valid;
  assign w_rx_ovr   = r_rx_ovr;
  assign w_rx_ferr  = r_rx_ferr;
  assign w_rx_byte  = r_rx_byte;
  assign uart_irpt  = r_rx_valid;
  assign o_rx_state = r_rx_state;
`else
  logic w_unused_rx;

  assign w_rx_valid  = 1'b0;
  assign w_rx_ovr    = 1'b0;
  assign w_rx_ferr   = 1'b0;
  assign w_rx_byte   = 8'd0;
  assign uart_irpt   = 1'b0;
  assign o_rx_state  = 2'd0;
  assign w_unused_rx = uart_rx;
`endif

endmodule

// File: tb/tb_uart_port.sv
// Directed bench for uart_port: bus driver tasks feed an expected-rdata queue drained by a monitor,
// plus direct checks of the serial line; RX scenarios run only when UART_RX_EN is defined.
module tb_uart_port;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_tx;
  logic       uart_rx = 1'b1;
  logic       uart_irpt;
  logic [1:0] tx_st, rx_st;

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  uart_port_if bus();

  uart_port #(.CLK_DIV(868), .TX_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .uart_tx    (uart_tx),
    .uart_rx    (uart_rx),
    .uart_irpt  (uart_irpt),
    .o_tx_state (tx_st),
    .o_rx_state (rx_st)
  );

  // Clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ready pulse consumes one expected rdata
  always @(negedge clk) begin
    if (rst && bus.uart_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", bus.uart_rdata, 32'hDEAD_BEEF);
      end else begin
        check(name_q.pop_front(), bus.uart_rdata, exp_q.pop_front());
      end
    end
  end

  // Driver: called on a negedge, returns on the negedge where ready is seen
  task automatic bus_xfer(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp);
    bit got = 0;
    exp_q.push_back(exp);
    name_q.push_back(name);
    bus.uart_addr  = addr;
    bus.uart_wdata = wdata;
    bus.uart_wstrb = wstrb;
    bus.uart_instr = 1'($urandom_range(0, 1));
    bus.uart_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.uart_ready === 1'b1) begin
        got = 1;
        break;
      end
    end
    bus.uart_valid = 1'b0;
    if (!got) begin
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
      check({name, "_timeout"}, 32'd0, 32'd1);
    end
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        lat = i;
        break;
      end
    end
  endtask

  // Samples one whole character starting at the current negedge; leaves us at the next one
  task automatic check_char(input int div, input logic [7:0] b);
    logic [9:0] frame, mid;
    int bad;
    frame = {1'b1, b, 1'b0};
    mid   = '0;
    bad   = 0;
    for (int j = 0; j < 10 * div; j++) begin
      if (uart_tx !== frame[j / div]) bad++;
      if (j % div == div / 2) mid[j / div] = uart_tx;
      @(negedge clk);
    end
    check($sformatf("tx_frame_%02h", b), {22'd0, mid}, {22'd0, frame});
    check($sformatf("tx_bad_samples_%02h", b), bad, 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uart_rx = f[k];
      repeat (div) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  initial begin
    int lat;
    bus.uart_valid = 1'b0;
    bus.uart_instr = 1'b0;
    bus.uart_addr  = 32'd0;
    bus.uart_wdata = 32'd0;
    bus.uart_wstrb = 4'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, bus.uart_ready}, 32'd0);
    check("rst_rdata", bus.uart_rdata, 32'd0);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_irpt", {31'd0, uart_irpt}, 32'd0);
    rst = 1'b1;
    bus_xfer("status_after_reset", 32'h4, 32'd0, 4'h0, 32'h0000_0002);
    @(negedge clk);
    check("rdata_idle_zero", bus.uart_rdata, 32'd0);
    check("tx_idle_high", {31'd0, uart_tx}, 32'd1);
    bus_xfer("div_after_reset", 32'hC, 32'd0, 4'h0, 32'd868);
    bus_xfer("txdata_read", 32'h0, 32'd0, 4'h0, 32'd0);

    // Single character 0xA5 at DIV=4
    bus_xfer("wr_div4", 32'hC, 32'd4, 4'hF, 32'd0);
    bus_xfer("wr_tx_a5", 32'h0, 32'hA5, 4'h1, 32'd0);
    wait_start(lat);
    check("tx_start_latency", lat, 1);
    fork
      check_char(4, 8'hA5);
      begin
        repeat (8) @(negedge clk);
        bus_xfer("status_busy", 32'h4, 32'd0, 4'h0, 32'h0000_0000);
      end
    join
    bus_xfer("status_done", 32'h4, 32'd0, 4'h0, 32'h0000_0002);

    // FIFO overflow with the shifter busy: 0x11 in flight, 22..55 queued, 66 dropped
    fork
      begin
        wait_start(lat);
        check_char(4, 8'h11);
        check_char(4, 8'h22);
        check_char(4, 8'h33);
        check_char(4, 8'h44);
        check_char(4, 8'h55);
        check("tx_line_idle_after_burst", {31'd0, uart_tx}, 32'd1);
      end
      begin
        bus_xfer("wr_tx_11", 32'h0, 32'h11, 4'h1, 32'd0);
        bus_xfer("wr_tx_22", 32'h0, 32'h22, 4'h1, 32'd0);
        bus_xfer("wr_tx_33", 32'h0, 32'h33, 4'h1, 32'd0);
        bus_xfer("wr_tx_44", 32'h0, 32'h44, 4'h1, 32'd0);
        bus_xfer("wr_tx_55", 32'h0, 32'h55, 4'h1, 32'd0);
        bus_xfer("wr_tx_66_drop", 32'h0, 32'h66, 4'h1, 32'd0);
        bus_xfer("status_full_ovf", 32'h4, 32'd0, 4'h0, 32'h0000_0009);
        bus_xfer("clr_ovf", 32'h4, 32'h8, 4'hF, 32'd0);
        bus_xfer("status_full_only", 32'h4, 32'd0, 4'h0, 32'h0000_0001);
      end
    join
    bus_xfer("status_after_burst", 32'h4, 32'd0, 4'h0, 32'h0000_0002);

`ifdef UART_RX_EN
    // Receive 0x3C at DIV=8
    bus_xfer("wr_div8", 32'hC, 32'd8, 4'hF, 32'd0);
    send_rx(8'h3C, 1'b1, 8);
    check("irpt_set", {31'd0, uart_irpt}, 32'd1);
    bus_xfer("status_rx_valid", 32'h4, 32'd0, 4'h0, 32'h0000_0006);
    bus_xfer("rxdata_3c", 32'h8, 32'd0, 4'h0, 32'h8000_003C);
    check("irpt_cleared", {31'd0, uart_irpt}, 32'd0);
    bus_xfer("rxdata_reread", 32'h8, 32'd0, 4'h0, 32'h0000_003C);

    // Overrun then framing error
    send_rx(8'h5A, 1'b1, 8);
    send_rx(8'hC3, 1'b1, 8);
    send_rx(8'h99, 1'b0, 8);
    repeat (16) @(negedge clk);
    bus_xfer("status_ovr_ferr", 32'h4, 32'd0, 4'h0, 32'h0000_0036);
    bus_xfer("rxdata_c3", 32'h8, 32'd0, 4'h0, 32'h8000_00C3);
    bus_xfer("clr_rx_flags", 32'h4, 32'h30, 4'hF, 32'd0);
    bus_xfer("status_rx_clean", 32'h4, 32'd0, 4'h0, 32'h0000_0002);
`else
    send_rx(8'h3C, 1'b1, 8);
    check("irpt_tied_low", {31'd0, uart_irpt}, 32'd0);
    bus_xfer("rxdata_absent", 32'h8, 32'd0, 4'h0, 32'h0000_0000);
`endif

    // DIV clamping, strobes, and an RX glitch at DIV=16
    bus_xfer("wr_div0", 32'hC, 32'd0, 4'hF, 32'd0);
    bus_xfer("div_clamped", 32'hC, 32'd0, 4'h0, 32'd2);
    bus_xfer("wr_div16", 32'hC, 32'd16, 4'hF, 32'd0);
    bus_xfer("wr_div_lo_only", 32'hC, 32'h0000_FF03, 4'h1, 32'd0);
    bus_xfer("div_lo_strobe", 32'hC, 32'd0, 4'h0, 32'd3);
    bus_xfer("wr_div16_again", 32'hC, 32'd16, 4'h3, 32'd0);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (400) @(negedge clk);
    bus_xfer("status_after_glitch", 32'h4, 32'd0, 4'h0, 32'h0000_0002);
`ifdef UART_RX_EN
    bus_xfer("rxdata_after_glitch", 32'h8, 32'd0, 4'h0, 32'h0000_00C3);
`else
    bus_xfer("rxdata_after_glitch", 32'h8, 32'd0, 4'h0, 32'h0000_0000);
`endif

    // Reset in the middle of a character
    bus_xfer("wr_tx_00", 32'h0, 32'h00, 4'h1, 32'd0);
    wait_start(lat);
    check("tx_start_before_abort", {31'd0, uart_tx}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_tx_high", {31'd0, uart_tx}, 32'd1);
    check("abort_tx_state", {30'd0, tx_st}, 32'd0);
    rst = 1'b1;
    bus_xfer("div_after_abort", 32'hC, 32'd0, 4'h0, 32'd868);
    bus_xfer("status_after_abort", 32'h4, 32'd0, 4'h0, 32'h0000_0002);

    // Final report
    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
